// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (C = CPU, L = loader)
// and the shared single-port synchronous memory.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic [DW-1:0] c_rdata;
    logic          c_ack;

    logic          l_req;
    logic          l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic [DW-1:0] l_rdata;
    logic          l_ack;

    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    logic [1:0]    gnt;

    // Arbiter side
    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_rdata, c_ack,
        input  l_req, l_we, l_addr, l_wdata,
        output l_rdata, l_ack,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata,
        output gnt
    );

    // Requester / memory side
    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_rdata, c_ack,
        output l_req, l_we, l_addr, l_wdata,
        input  l_rdata, l_ack,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata,
        input  gnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port synchronous memory
// between the CPU port (C) and a loader/debug port (L). One access at a
// time: IDLE -> ISSUE -> (WAIT x RD_LAT for reads) -> ACK -> IDLE.
module mem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    // Wait counter is 4 bits, enough for the 1..15 latency range.
    localparam logic [3:0] LAT = 4'(RD_LAT);

    state_t        r_state;
    logic [1:0]    r_gnt;       // {L,C} one-hot owner
    logic          r_last;      // 1: L was granted last, 0: C was
    logic [3:0]    r_cnt;
    logic          r_m_en;
    logic          r_m_we;
    logic [AW-1:0] r_m_addr;
    logic [DW-1:0] r_m_wdata;
    logic          r_c_ack;
    logic          r_l_ack;
    logic [DW-1:0] r_c_rdata;
    logic [DW-1:0] r_l_rdata;

    logic          w_any;
    logic          w_pick_l;

    // Winner select: a lone requester wins; on a tie the port not granted last wins.
    always_comb begin
        w_any    = bus.c_req | bus.l_req;
        w_pick_l = bus.l_req & (~bus.c_req | ~r_last);
    end

    // Sequencer FSM; every output is a register written here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_gnt     <= 2'b00;
            r_last    <= 1'b1;
            r_cnt     <= 4'd0;
            r_m_en    <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_c_ack   <= 1'b0;
            r_l_ack   <= 1'b0;
            r_c_rdata <= '0;
            r_l_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        // Command is latched straight into the memory-side
                        // registers, so m_addr/m_wdata hold it afterwards.
                        r_gnt     <= w_pick_l ? 2'b10 : 2'b01;
                        r_last    <= w_pick_l;
                        r_m_en    <= 1'b1;
                        r_m_we    <= w_pick_l ? bus.l_we    : bus.c_we;
                        r_m_addr  <= w_pick_l ? bus.l_addr  : bus.c_addr;
                        r_m_wdata <= w_pick_l ? bus.l_wdata : bus.c_wdata;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_m_en <= 1'b0;
                    r_m_we <= 1'b0;
                    if (r_m_we) begin
                        r_c_ack <= r_gnt[0];
                        r_l_ack <= r_gnt[1];
                        r_state <= S_ACK;
                    end else begin
                        r_cnt   <= LAT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    // Count of 1 marks the cycle m_rdata is valid.
                    if (r_cnt == 4'd1) begin
                        if (r_gnt[0]) r_c_rdata <= bus.m_rdata;
                        if (r_gnt[1]) r_l_rdata <= bus.m_rdata;
                        r_c_ack <= r_gnt[0];
                        r_l_ack <= r_gnt[1];
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_c_ack <= 1'b0;
                    r_l_ack <= 1'b0;
                    r_gnt   <= 2'b00;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Drive the bus from the registered outputs.
    always_comb begin
        bus.gnt     = r_gnt;
        bus.m_en    = r_m_en;
        bus.m_we    = r_m_we;
        bus.m_addr  = r_m_addr;
        bus.m_wdata = r_m_wdata;
        bus.c_ack   = r_c_ack;
        bus.l_ack   = r_l_ack;
        bus.c_rdata = r_c_rdata;
        bus.l_rdata = r_l_rdata;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: main instance with RD_LAT=2 plus RD_LAT=1 and 15
// instances, a shared memory model, and a transaction-level reference.
module tb_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) ifa ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) ifb ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) ifc ();

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut   (.clk(clk), .reset(reset), .bus(ifa));
    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1))   dut1  (.clk(clk), .reset(reset), .bus(ifb));
    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(15))  dut15 (.clk(clk), .reset(reset), .bus(ifc));

    function automatic logic [31:0] init_val(input int i);
        if (i == 4) return 32'hDEADBEEF;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Memory model: 256 words, read data appears RD_LAT cycles after m_en.
    logic [31:0] mem [0:255];
    logic [31:0] rda [1:15];
    logic [31:0] rdb [1:15];
    logic [31:0] rdc [1:15];
    bit          init_done;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            init_done <= 1'b1;
        end else if (ifa.m_en && ifa.m_we) begin
            mem[ifa.m_addr[9:2]] <= ifa.m_wdata;
        end
        rda[1] <= (ifa.m_en && !ifa.m_we) ? mem[ifa.m_addr[9:2]] : $urandom;
        rdb[1] <= (ifb.m_en && !ifb.m_we) ? mem[ifb.m_addr[9:2]] : $urandom;
        rdc[1] <= (ifc.m_en && !ifc.m_we) ? mem[ifc.m_addr[9:2]] : $urandom;
        for (int i = 2; i <= 15; i++) begin
            rda[i] <= rda[i-1];
            rdb[i] <= rdb[i-1];
            rdc[i] <= rdc[i-1];
        end
    end

    assign ifa.m_rdata = rda[LAT];
    assign ifb.m_rdata = rdb[1];
    assign ifc.m_rdata = rdc[15];

    // Reference state
    logic [31:0] ref_mem [0:255];
    bit          ref_last_l = 1'b1;
    logic [31:0] ref_crd = '0;
    logic [31:0] ref_lrd = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise the requested ports in the current (idle) cycle and check every
    // cycle until both accesses are complete and the arbiter is idle again.
    task automatic run_pair(input bit c_on, input bit c_we, input logic [31:0] c_a, input logic [31:0] c_d,
                            input bit l_on, input bit l_we, input logic [31:0] l_a, input logic [31:0] l_d);
        int          n;
        bit          pl  [2];
        bit          pwe [2];
        logic [31:0] pad [2];
        logic [31:0] pdt [2];
        logic [31:0] pex [2];
        int          iss [2];
        int          ack [2];
        int          endc;
        n = int'(c_on) + int'(l_on);
        if (c_on && l_on) pl[0] = !ref_last_l;
        else              pl[0] = l_on;
        pl[1] = !pl[0];
        for (int k = 0; k < 2; k++) begin
            pwe[k] = pl[k] ? l_we : c_we;
            pad[k] = pl[k] ? l_a  : c_a;
            pdt[k] = pl[k] ? l_wdata_sel(l_d) : c_d;
        end
        // Service order determines what each read returns.
        for (int k = 0; k < n; k++) begin
            if (pwe[k]) ref_mem[pad[k][9:2]] = pdt[k];
            else        pex[k] = ref_mem[pad[k][9:2]];
            ref_last_l = pl[k];
        end
        iss[0] = 1;
        ack[0] = iss[0] + (pwe[0] ? 1 : 1 + LAT);
        iss[1] = ack[0] + 2;
        ack[1] = iss[1] + (pwe[1] ? 1 : 1 + LAT);
        endc   = ack[n-1] + 1;

        if (c_on) begin
            ifa.c_req = 1'b1; ifa.c_we = c_we; ifa.c_addr = c_a; ifa.c_wdata = c_d;
        end
        if (l_on) begin
            ifa.l_req = 1'b1; ifa.l_we = l_we; ifa.l_addr = l_a; ifa.l_wdata = l_d;
        end

        for (int cyc = 1; cyc <= endc; cyc++) begin
            logic [1:0] eg;
            bit         em, eca, ela;
            step();
            eg = 2'b00; em = 1'b0; eca = 1'b0; ela = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (cyc == ack[k] + 1) begin
                    if (pl[k]) ifa.l_req = 1'b0;
                    else       ifa.c_req = 1'b0;
                end
                if (cyc >= iss[k] && cyc <= ack[k]) eg = pl[k] ? 2'b10 : 2'b01;
                if (cyc == iss[k]) em = 1'b1;
                if (cyc == ack[k]) begin
                    if (pl[k]) ela = 1'b1;
                    else       eca = 1'b1;
                end
            end
            chk("ctl{gnt,m_en,c_ack,l_ack}", {ifa.gnt, ifa.m_en, ifa.c_ack, ifa.l_ack}, {eg, em, eca, ela});
            for (int k = 0; k < n; k++) begin
                if (cyc == iss[k]) begin
                    chk("m_addr", ifa.m_addr, pad[k]);
                    chk("m_we", ifa.m_we, pwe[k]);
                    if (pwe[k]) chk("m_wdata", ifa.m_wdata, pdt[k]);
                end
                if (cyc == ack[k]) begin
                    if (!pwe[k]) begin
                        if (pl[k]) ref_lrd = pex[k];
                        else       ref_crd = pex[k];
                    end
                    chk("c_rdata", ifa.c_rdata, ref_crd);
                    chk("l_rdata", ifa.l_rdata, ref_lrd);
                end
            end
        end
    endtask

    function automatic logic [31:0] l_wdata_sel(input logic [31:0] d);
        return d;
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [7:0] w;
        w = 8'($urandom_range(0, 15));
        return {22'd0, w, 2'b00};
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctl"}, {ifa.gnt, ifa.m_en, ifa.m_we, ifa.c_ack, ifa.l_ack}, 6'd0);
        chk({tag, "_m_addr"}, ifa.m_addr, 32'd0);
        chk({tag, "_m_wdata"}, ifa.m_wdata, 32'd0);
        chk({tag, "_c_rdata"}, ifa.c_rdata, 32'd0);
        chk({tag, "_l_rdata"}, ifa.l_rdata, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] exp;
        bit          first_l;
        int          cnt [2];
        logic [31:0] cur_a [2];
        logic [31:0] cur_d [2];

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        ifa.c_req = 0; ifa.c_we = 0; ifa.c_addr = '0; ifa.c_wdata = '0;
        ifa.l_req = 0; ifa.l_we = 0; ifa.l_addr = '0; ifa.l_wdata = '0;
        ifb.c_req = 0; ifb.c_we = 0; ifb.c_addr = '0; ifb.c_wdata = '0;
        ifb.l_req = 0; ifb.l_we = 0; ifb.l_addr = '0; ifb.l_wdata = '0;
        ifc.c_req = 0; ifc.c_we = 0; ifc.c_addr = '0; ifc.c_wdata = '0;
        ifc.l_req = 0; ifc.l_we = 0; ifc.l_addr = '0; ifc.l_wdata = '0;

        step();
        step();
        chk_reset_vals("reset");
        reset = 1'b0;
        step();

        // Both reads from reset: C (0x10 -> DEADBEEF) first, ack 4; L issue 6, ack 9.
        run_pair(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        chk("c_rdata_deadbeef", ifa.c_rdata, 32'hDEADBEEF);

        // L write then C read of the same word.
        run_pair(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678);
        run_pair(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("c_rdata_after_lwrite", ifa.c_rdata, 32'h12345678);

        // Continuous write traffic on both ports: 6 acks, alternating, every 3 cycles.
        first_l = !ref_last_l;
        cnt[0] = 0; cnt[1] = 0;
        for (int p = 0; p < 2; p++) begin
            cur_a[p] = rnd_addr();
            cur_d[p] = $urandom;
        end
        ifa.c_req = 1; ifa.c_we = 1; ifa.c_addr = cur_a[0]; ifa.c_wdata = cur_d[0];
        ifa.l_req = 1; ifa.l_we = 1; ifa.l_addr = cur_a[1]; ifa.l_wdata = cur_d[1];
        for (int cyc = 1; cyc <= 18; cyc++) begin
            int  k;
            bit  o;
            logic [1:0] eg;
            logic [1:0] eack;
            step();
            eg = 2'b00; eack = 2'b00;
            if (cyc <= 17 && (cyc % 3) != 0) begin
                k = (cyc - 1) / 3;
                o = first_l ^ k[0];
                eg = o ? 2'b10 : 2'b01;
                if ((cyc % 3) == 1) begin
                    chk("cont_m_en_we", {ifa.m_en, ifa.m_we}, 2'b11);
                    chk("cont_m_addr", ifa.m_addr, cur_a[o]);
                    chk("cont_m_wdata", ifa.m_wdata, cur_d[o]);
                    ref_mem[cur_a[o][9:2]] = cur_d[o];
                end else begin
                    eack = o ? 2'b01 : 2'b10;
                end
            end
            chk("cont_gnt", ifa.gnt, eg);
            chk("cont_ack{c,l}", {ifa.c_ack, ifa.l_ack}, eack);
            if ((cyc % 3) == 0) begin
                k = (cyc - 3) / 3;
                o = first_l ^ k[0];
                cnt[o]++;
                if (cnt[o] < 3) begin
                    cur_a[o] = rnd_addr();
                    cur_d[o] = $urandom;
                end
                if (o) begin
                    ifa.l_req = (cnt[o] < 3); ifa.l_addr = cur_a[o]; ifa.l_wdata = cur_d[o];
                end else begin
                    ifa.c_req = (cnt[o] < 3); ifa.c_addr = cur_a[o]; ifa.c_wdata = cur_d[o];
                end
            end
        end
        ref_last_l = !first_l;

        // Reset in a WAIT cycle of a C read: no ack, immediate reset values.
        ifa.c_req = 1; ifa.c_we = 0; ifa.c_addr = rnd_addr();
        step();
        step();
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        ifa.c_req = 0;
        ref_crd = '0; ref_lrd = '0; ref_last_l = 1'b1;
        step();
        reset = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            step();
            chk("post_rst_idle", {ifa.gnt, ifa.c_ack, ifa.l_ack, ifa.m_en}, 5'd0);
        end
        run_pair(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Latency extremes: C read ack in cycle 3 (RD_LAT=1) and 17 (RD_LAT=15).
        a = rnd_addr();
        exp = ref_mem[a[9:2]];
        ifb.c_req = 1; ifb.c_we = 0; ifb.c_addr = a;
        ifc.c_req = 1; ifc.c_we = 0; ifc.c_addr = a;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            step();
            if (cyc == 4)  ifb.c_req = 0;
            if (cyc == 18) ifc.c_req = 0;
            chk("lat1_c_ack", ifb.c_ack, (cyc == 3));
            chk("lat15_c_ack", ifc.c_ack, (cyc == 17));
            if (cyc == 3)  chk("lat1_c_rdata", ifb.c_rdata, exp);
            if (cyc == 17) chk("lat15_c_rdata", ifc.c_rdata, exp);
        end

        // Randomized traffic, small address range to create read-after-write hits.
        for (int it = 0; it < 40; it++) begin
            bit cn, ln;
            int gap;
            cn = 1'($urandom_range(0, 1));
            ln = cn ? 1'($urandom_range(0, 1)) : 1'b1;
            run_pair(cn, 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
                     ln, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the multicycle MIPS unified instruction/data memory. Shares one single-port synchronous memory between the CPU datapath (port C) and a loader/debug port (port L) using round-robin arbitration. Issues one access at a time, inserts wait states for the memory's fixed read latency, and returns a one-cycle acknowledge per completed access. The CPU control FSM holds in its current state until `c_ack`.

## Interface
- `AW`, 32, address width (byte address, passed through unmodified)
- `DW`, 32, data width
- `RD_LAT`, 2, memory read latency in cycles, legal range 1..15

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `c_req`  in  1  CPU access request, held until `c_ack`
- `c_we`  in  1  CPU write (1) / read (0)
- `c_addr`  in  AW  CPU address
- `c_wdata`  in  DW  CPU write data
- `c_rdata`  out  DW  CPU read data
- `c_ack`  out  1  CPU access complete, one-cycle pulse
- `l_req`, `l_we`, `l_addr`, `l_wdata`, `l_rdata`, `l_ack`  same as the CPU signals, for port L
- `m_en`  out  1  memory access strobe
- `m_we`  out  1  memory write enable
- `m_addr`  out  AW  memory address
- `m_wdata`  out  DW  memory write data
- `m_rdata`  in  DW  memory read data, valid `RD_LAT` cycles after the `m_en` cycle
- `gnt`  out  2  one-hot current owner {L,C}; 00 when idle

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE
  - If no request, stay in IDLE.
  - If exactly one request, grant that port.
  - If both `c_req` and `l_req` are high, grant the port not named by the `last` pointer.
  - On grant: register `we`, `addr` and `wdata` from the winner, set `gnt`, update `last` to the winner, and go to ISSUE.
- ISSUE (one cycle)
  - `m_en`=1; `m_we`, `m_addr` and `m_wdata` are driven from the registered command.
  - A write goes to ACK.
  - A read loads the wait counter with `RD_LAT` and goes to WAIT.
- WAIT
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1, `m_rdata` is captured into the owner's rdata register, and the FSM goes to ACK.
- ACK (one cycle)
  - Owner's ack=1; `gnt` is still valid; next state is IDLE.
- `c_rdata` and `l_rdata` are registered per port. Each updates only on a completed read by that port and holds otherwise. Writes never change them.
- `m_en`=0 outside ISSUE. `m_addr`, `m_wdata` and `m_we` hold the last command, and `m_we`=0 whenever `m_en`=0.
- Requester rules:
  - `req`, `we`, `addr` and `wdata` are stable from assertion through the ack cycle.
  - `req` is low in the cycle after ack unless a new access is intended.
  - Dropping `req` before ack is illegal; behaviour is unspecified.
- Requests arriving during ISSUE, WAIT or ACK wait. Only one access is outstanding at a time.

## Timing
- Reset values:
  - state IDLE, `gnt`=00, `last`=L (so C wins the first tie).
  - `m_en`=0, `m_we`=0, `m_addr`=0, `m_wdata`=0.
  - `c_ack`=0, `l_ack`=0, `c_rdata`=0, `l_rdata`=0.
- With `req` first high in cycle R while IDLE:
  - ISSUE is cycle R+1.
  - Write: ack in cycle R+2.
  - Read: data is sampled at the end of cycle R+1+`RD_LAT` and ack is in cycle R+2+`RD_LAT`.
  - Rdata is valid from the ack cycle onward.
- Back-to-back: the IDLE cycle after ACK can grant again. Minimum spacing between acks is 3 cycles for a write and 3+`RD_LAT` for a read.
- Both requesters continuously active: grants strictly alternate C, L, C, L…
- Reset asserted mid-access (any state):
  - Immediate return to reset values; the access is dropped with no ack.
  - Requesters must re-issue after reset.
  - A write already strobed in ISSUE may have taken effect in memory.

## Test plan
- C read, `RD_LAT`=2, `c_addr`=0x10, memory word 0xDEADBEEF; `c_req` high in cycle 0 -> `m_en`=1 with `m_addr`=0x10 in cycle 1; `c_ack`=1 and `c_rdata`=0xDEADBEEF in cycle 4; `gnt`=01 during cycles 1-4.
- L write, addr 0x20, data 0x12345678, `l_req` high in cycle 0 -> `m_en`=`m_we`=1 in cycle 1; `l_ack`=1 in cycle 2; `l_rdata` unchanged; a later C read of 0x20 returns 0x12345678.
- `c_req` and `l_req` both high from reset, both reads -> C is granted first (ack cycle 4), then L (ISSUE cycle 6, ack cycle 9); a C re-request in cycle 5 is served only after L.
- Both requesters hold continuous write traffic -> 6 acks alternate C, L, C, L, C, L, one every 3 cycles.
- Reset pulsed in a WAIT cycle of a C read -> `c_ack` is never asserted; all outputs are at reset values the same cycle; a re-issued C read completes normally.
- `RD_LAT`=1 and `RD_LAT`=15 builds: C read ack cycle is 3 and 17 respectively, and the captured data matches memory.
